// File: rtl/board_store_if.sv
// Playfield access bus: cell read (pos -> in_id), lock-time cell write, line-clear control.
// Latency: none; signal bundle only.
// Backpressure: ready low means writes and commits are dropped by the store, not queued.
//
// master: collision / piece-placement side.
// slave : board_store.
interface board_store_if #(
    parameter int IDW = 3
);
    logic [4:0]     pos_y;
    logic [4:0]     pos_x;
    logic [IDW-1:0] in_id;
    logic           wr;
    logic [4:0]     wr_y;
    logic [4:0]     wr_x;
    logic [IDW-1:0] wr_id;
    logic           commit;
    logic           ready;
    logic           done;
    logic [2:0]     lines;
    logic [9:0]     total_lines;

    modport master (
        output pos_y, pos_x, wr, wr_y, wr_x, wr_id, commit,
        input  in_id, ready, done, lines, total_lines
    );

    modport slave (
        input  pos_y, pos_x, wr, wr_y, wr_x, wr_id, commit,
        output in_id, ready, done, lines, total_lines
    );
endinterface

// File: rtl/board_store.sv
// Tetris playfield register array with combinational cell reads and a row-at-a-time line-clear engine.
// Latency: reads combinational; writes visible next cycle; a clear pass takes HEIGHT+2k cycles from commit to done.
// Backpressure: ready is low during a pass; wr/commit arriving then are ignored, never queued.
//
// Ports: clk, rst_n (async active-low), bus (board_store_if.slave):
//   pos_y/pos_x -> in_id   read port (x out of range = wall code, y above board = empty)
//   wr/wr_y/wr_x/wr_id     cell write, taken only while ready
//   commit                 start a line-clear pass
//   ready/done             idle flag / end-of-pass pulse
//   lines/total_lines      rows cleared by last pass / since reset (saturating)
module board_store #(
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 20,
    parameter int IDW    = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    board_store_if.slave bus
);
    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [4:0]    WIDTH5   = 5'(WIDTH);
    localparam logic [4:0]    HEIGHT5  = 5'(HEIGHT);
    localparam logic [YW-1:0] LAST_ROW = YW'(HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] cells [HEIGHT][WIDTH];
    logic [YW-1:0]  r_q;
    logic [2:0]     lines_q;
    logic [9:0]     total_q;

    logic row_full;
    logic wr_ok;
    logic start;
    logic r_inc;
    logic do_write;
    logic do_shift;

    // Read port: out-of-range columns look like wall so collision sees the sides
    // as solid; rows above the board are open spawn space.
    always_comb begin
        bus.in_id = '0;
        if (bus.pos_x >= WIDTH5) begin
            bus.in_id = '1;
        end else if (bus.pos_y < HEIGHT5) begin
            bus.in_id = cells[bus.pos_y[YW-1:0]][bus.pos_x[XW-1:0]];
        end
    end

    always_comb begin
        row_full = 1'b1;
        for (int x = 0; x < WIDTH; x++) begin
            if (cells[r_q][x] == '0) begin
                row_full = 1'b0;
            end
        end
    end

    assign wr_ok = bus.wr && (bus.wr_x < WIDTH5) && (bus.wr_y < HEIGHT5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        r_inc    = 1'b0;
        do_write = 1'b0;
        do_shift = 1'b0;
        case (state_q)
            IDLE: begin
                // A write alongside commit lands on the same edge, so the scan
                // that starts next cycle already sees it.
                do_write = wr_ok;
                if (bus.commit) begin
                    start   = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (row_full) begin
                    state_d = SHIFT;
                end else if (r_q == LAST_ROW) begin
                    state_d = DONE;
                end else begin
                    r_inc = 1'b1;
                end
            end
            SHIFT: begin
                // r is left alone: the row that drops into r gets re-checked.
                do_shift = 1'b1;
                state_d  = SCAN;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            lines_q <= '0;
            total_q <= '0;
        end else begin
            if (start) begin
                r_q     <= '0;
                lines_q <= '0;
            end else if (r_inc) begin
                r_q <= r_q + 1'b1;
            end
            if (do_shift) begin
                if (lines_q != 3'd7) begin
                    lines_q <= lines_q + 3'd1;
                end
                if (total_q != 10'd1023) begin
                    total_q <= total_q + 10'd1;
                end
            end
        end
    end

    // Cell array. A shift moves every row at or above r in a single edge, so a
    // reset can never land on a half-shifted board.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int y = 0; y < HEIGHT; y++) begin
                for (int x = 0; x < WIDTH; x++) begin
                    cells[y][x] <= '0;
                end
            end
        end else if (do_write) begin
            cells[bus.wr_y[YW-1:0]][bus.wr_x[XW-1:0]] <= bus.wr_id;
        end else if (do_shift) begin
            for (int y = 0; y < HEIGHT - 1; y++) begin
                if (YW'(y) >= r_q) begin
                    for (int x = 0; x < WIDTH; x++) begin
                        cells[y][x] <= cells[y + 1][x];
                    end
                end
            end
            for (int x = 0; x < WIDTH; x++) begin
                cells[HEIGHT - 1][x] <= '0;
            end
        end
    end

    assign bus.ready       = (state_q == IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.lines       = lines_q;
    assign bus.total_lines = total_q;
endmodule
